// File: rtl/div_64_seq.sv
// Iterative radix-2 restoring divider (signed/unsigned) with valid/ready on both sides.
// One quotient bit per cycle; magnitudes are divided and signs are re-applied in FIX.
module div_64_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;

    // Partial remainder is carried one bit wider here so the trial subtraction's sign is visible.
    shifted = {p_q, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_q_d = op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sign_r_d = op_signed & dividend[WIDTH-1];
          dvs_d    = cond_neg(divisor, op_signed & divisor[WIDTH-1]);
          q_d      = cond_neg(dividend, op_signed & dividend[WIDTH-1]);
          p_d      = '0;
          cnt_d    = CNT_W'(WIDTH);
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          p_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          p_d = shifted[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = cond_neg(q_q, sign_q_q);
        rem_d   = cond_neg(p_q, sign_r_q);
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      q_q      <= q_d;
      dvs_q    <= dvs_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_64_seq.sv
// Directed bench for div_64_seq: vector table plus backpressure, overflow and mid-operation reset sequences.
module tb_div_64_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        op_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int ntests = 0;
  int nfail  = 0;

  div_64_seq #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] eq;
    logic [63:0] er;
    logic        edbz;
    int          elat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand pair, complete the accept edge, then scramble the inputs.
  task automatic issue(input logic sgn, input logic [63:0] a, input logic [63:0] b);
    int w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) check("issue_wait_in_ready", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    op_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    op_signed = ~sgn;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
  endtask

  // Latency counts edges including the accept edge.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int lat;
    int spurious;
    logic [63:0] hold_q, hold_r;
    logic        stable;

    vecs[0]  = '{"u_100_7",     1'b0, 64'd100,                64'd7,                 64'd14,                64'd2,                 1'b0, 66};
    vecs[1]  = '{"s_m100_7",    1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66};
    // 2^64-100 is an exact multiple of 7.
    vecs[2]  = '{"u_ff9c_7",    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                 64'h2492_4924_9249_2484, 64'd0,                 1'b0, 66};
    vecs[3]  = '{"u_div0",      1'b0, 64'h1234,               64'd0,                 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234,              1'b1, 1};
    vecs[4]  = '{"s_100_m7",    1'b1, 64'd100,                64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2,                 1'b0, 66};
    vecs[5]  = '{"s_m100_m7",   1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14,                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66};
    vecs[6]  = '{"u_5_10",      1'b0, 64'd5,                  64'd10,                64'd0,                 64'd5,                 1'b0, 66};
    vecs[7]  = '{"u_max_1",     1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                 1'b0, 66};
    vecs[8]  = '{"s_m5_div0",   1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1};
    vecs[9]  = '{"s_7_7",       1'b1, 64'd7,                  64'd7,                 64'd1,                 64'd0,                 1'b0, 66};
    vecs[10] = '{"u_2p63_3",    1'b0, 64'h8000_0000_0000_0000, 64'd3,                 64'h2AAA_AAAA_AAAA_AAAA, 64'd2,                 1'b0, 66};

    reset     = 1'b0;
    in_valid  = 1'b0;
    op_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      if (vecs[i].elat > 1) check({vecs[i].name, "_busy_in_ready"}, 64'(in_ready), 64'd0);
      wait_result(lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].elat));
      check({vecs[i].name, "_quotient"}, quotient, vecs[i].eq);
      check({vecs[i].name, "_remainder"}, remainder, vecs[i].er);
      check({vecs[i].name, "_dbz"}, 64'(div_by_zero), 64'(vecs[i].edbz));
      check({vecs[i].name, "_done_in_ready"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check({vecs[i].name, "_consumed"}, 64'({out_valid, in_ready}), 64'b01);
    end

    // Signed overflow MIN / -1 under 10 cycles of backpressure.
    out_ready = 1'b0;
    issue(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_result(lat);
    check("ovf_latency", 64'(lat), 64'd66);
    check("ovf_quotient", quotient, 64'h8000_0000_0000_0000);
    check("ovf_remainder", remainder, 64'd0);
    check("ovf_dbz", 64'(div_by_zero), 64'd0);
    hold_q = quotient;
    hold_r = remainder;
    stable = 1'b1;
    in_valid = 1'b1;
    dividend = 64'd50;
    divisor  = 64'd5;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || quotient !== hold_q || remainder !== hold_r) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("ovf_stall_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("ovf_release", 64'({out_valid, in_ready}), 64'b01);

    // Abort a division with reset at cycle 30, then run a fresh one.
    issue(1'b0, 64'd100, 64'd7);
    repeat (29) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_outputs", {quotient[31:0], remainder[31:0]}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    spurious = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    check("abort_no_result", 64'(spurious), 64'd0);
    issue(1'b0, 64'd9, 64'd3);
    wait_result(lat);
    check("post_abort_latency", 64'(lat), 64'd66);
    check("post_abort_quotient", quotient, 64'd3);
    check("post_abort_remainder", remainder, 64'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
